// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared encodings for the scoreboard game controller
package score_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_WON_A = 2'b10,
        ST_WON_B = 2'b11
    } state_t;

    localparam logic TEAM_A = 1'b0;
    localparam logic TEAM_B = 1'b1;
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam int DEF_WIN_SCORE = 11;

endpackage

// File: rtl/score_ctrl_btn_edge.sv
// rtl/score_ctrl_btn_edge.sv - button history register with rising-edge pulse
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic btn_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn;
        end
    end

    assign pulse = btn & ~btn_q;

endmodule

// File: rtl/score_ctrl.sv
// rtl/score_ctrl.sv - two-team score controller with round-robin update channel
module score_ctrl
    import score_pkg::*;
#(
    parameter int BW        = 7,
    parameter int WIN_SCORE = DEF_WIN_SCORE
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          clr_i,
    input  logic          btn_a_up_i,
    input  logic          btn_a_dn_i,
    input  logic          btn_b_up_i,
    input  logic          btn_b_dn_i,
    input  logic          upd_ready_i,
    output logic          upd_valid_o,
    output logic          upd_team_o,
    output logic          upd_dir_o,
    output logic [BW-1:0] score_a_o,
    output logic [BW-1:0] score_b_o,
    output logic [1:0]    state_o,
    output logic          drop_o
);

    localparam logic [BW-1:0] WIN = BW'(WIN_SCORE);

    logic ev_a_up, ev_a_dn, ev_b_up, ev_b_dn;

    btn_edge u_a_up (.clk(clk_i), .rst_n(rst_i), .btn(btn_a_up_i), .pulse(ev_a_up));
    btn_edge u_a_dn (.clk(clk_i), .rst_n(rst_i), .btn(btn_a_dn_i), .pulse(ev_a_dn));
    btn_edge u_b_up (.clk(clk_i), .rst_n(rst_i), .btn(btn_b_up_i), .pulse(ev_b_up));
    btn_edge u_b_dn (.clk(clk_i), .rst_n(rst_i), .btn(btn_b_dn_i), .pulse(ev_b_dn));

    state_t        state, state_nxt;
    logic          pend_a, pend_b, dir_a, dir_b, rr;
    logic          valid, team, dir, drop;
    logic [BW-1:0] score_a, score_b;

    logic          pend_a_nxt, pend_b_nxt, dir_a_nxt, dir_b_nxt, rr_nxt;
    logic          valid_nxt, team_nxt, dir_nxt, drop_nxt;
    logic [BW-1:0] score_a_nxt, score_b_nxt;
    logic          commit, free, win_a, win_b, gnt_a, gnt_b;

    // A cleared handshake never commits, so clr cannot also trigger a win.
    assign commit = valid & upd_ready_i & ~clr_i;
    assign free   = ~valid | commit;
    assign win_a  = commit & (team == TEAM_A) & (dir == DIR_UP) & ((score_a + BW'(1)) == WIN);
    assign win_b  = commit & (team == TEAM_B) & (dir == DIR_UP) & ((score_b + BW'(1)) == WIN);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_i) state_nxt = ST_PLAY;
            ST_PLAY: begin
                if (win_a)      state_nxt = ST_WON_A;
                else if (win_b) state_nxt = ST_WON_B;
            end
            default: ;
        endcase
        if (clr_i) state_nxt = ST_IDLE;
    end

    always_comb begin
        pend_a_nxt  = pend_a;
        pend_b_nxt  = pend_b;
        dir_a_nxt   = dir_a;
        dir_b_nxt   = dir_b;
        rr_nxt      = rr;
        valid_nxt   = valid & ~commit;
        team_nxt    = team;
        dir_nxt     = dir;
        drop_nxt    = 1'b0;
        score_a_nxt = score_a;
        score_b_nxt = score_b;
        gnt_a       = 1'b0;
        gnt_b       = 1'b0;

        if (commit) begin
            if (team == TEAM_A) begin
                if (dir == DIR_UP)        score_a_nxt = score_a + BW'(1);
                else if (score_a != '0)   score_a_nxt = score_a - BW'(1);
            end else begin
                if (dir == DIR_UP)        score_b_nxt = score_b + BW'(1);
                else if (score_b != '0)   score_b_nxt = score_b - BW'(1);
            end
        end

        if (free) begin
            if (pend_a && pend_b) begin
                gnt_a  = (rr == TEAM_B);
                gnt_b  = (rr == TEAM_A);
                rr_nxt = ~rr;
            end else begin
                gnt_a = pend_a;
                gnt_b = pend_b;
            end
        end

        // Down requests are filtered against the post-commit score.
        if (gnt_a) begin
            pend_a_nxt = 1'b0;
            if (dir_a == DIR_UP || score_a_nxt != '0) begin
                valid_nxt = 1'b1;
                team_nxt  = TEAM_A;
                dir_nxt   = dir_a;
            end
        end
        if (gnt_b) begin
            pend_b_nxt = 1'b0;
            if (dir_b == DIR_UP || score_b_nxt != '0) begin
                valid_nxt = 1'b1;
                team_nxt  = TEAM_B;
                dir_nxt   = dir_b;
            end
        end

        if (state == ST_PLAY) begin
            if (ev_a_up ^ ev_a_dn) begin
                if (pend_a) begin
                    drop_nxt = 1'b1;
                end else begin
                    pend_a_nxt = 1'b1;
                    dir_a_nxt  = ev_a_up;
                end
            end
            if (ev_b_up ^ ev_b_dn) begin
                if (pend_b) begin
                    drop_nxt = 1'b1;
                end else begin
                    pend_b_nxt = 1'b1;
                    dir_b_nxt  = ev_b_up;
                end
            end
        end

        if (win_a || win_b) begin
            pend_a_nxt = 1'b0;
            pend_b_nxt = 1'b0;
            valid_nxt  = 1'b0;
        end

        if (clr_i) begin
            pend_a_nxt  = 1'b0;
            pend_b_nxt  = 1'b0;
            valid_nxt   = 1'b0;
            drop_nxt    = 1'b0;
            score_a_nxt = '0;
            score_b_nxt = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pend_a  <= 1'b0;
            pend_b  <= 1'b0;
            dir_a   <= 1'b0;
            dir_b   <= 1'b0;
            rr      <= TEAM_B;
            valid   <= 1'b0;
            team    <= 1'b0;
            dir     <= 1'b0;
            drop    <= 1'b0;
            score_a <= '0;
            score_b <= '0;
        end else begin
            pend_a  <= pend_a_nxt;
            pend_b  <= pend_b_nxt;
            dir_a   <= dir_a_nxt;
            dir_b   <= dir_b_nxt;
            rr      <= rr_nxt;
            valid   <= valid_nxt;
            team    <= team_nxt;
            dir     <= dir_nxt;
            drop    <= drop_nxt;
            score_a <= score_a_nxt;
            score_b <= score_b_nxt;
        end
    end

    assign upd_valid_o = valid;
    assign upd_team_o  = team;
    assign upd_dir_o   = dir;
    assign score_a_o   = score_a;
    assign score_b_o   = score_b;
    assign state_o     = state;
    assign drop_o      = drop;

endmodule

// File: tb/tb_score_ctrl.sv
// tb/tb_score_ctrl.sv - directed and random checks of score_ctrl against a game model
module tb_score_ctrl;

    localparam int BW  = 7;
    localparam int WIN = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          clr = 1'b0;
    logic          ready = 1'b0;
    logic [3:0]    btn = 4'b0;  // {b_dn, b_up, a_dn, a_up}
    logic          upd_valid, upd_team, upd_dir, drop;
    logic [BW-1:0] score_a, score_b;
    logic [1:0]    state;

    int checks = 0;
    int failures = 0;
    int drop_cnt = 0;
    int valid_cnt = 0;
    bit hs_q[$];

    int m_score[2];
    bit m_pend[2];
    bit m_pdir[2];
    bit m_prev[4];
    bit m_valid, m_team, m_dir, m_rr, m_drop;
    int m_state;

    score_ctrl #(.BW(BW), .WIN_SCORE(WIN)) dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .clr_i(clr),
        .btn_a_up_i(btn[0]), .btn_a_dn_i(btn[1]), .btn_b_up_i(btn[2]), .btn_b_dn_i(btn[3]),
        .upd_ready_i(ready), .upd_valid_o(upd_valid), .upd_team_o(upd_team), .upd_dir_o(upd_dir),
        .score_a_o(score_a), .score_b_o(score_b), .state_o(state), .drop_o(drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of the game rules, applied to the inputs present at this edge.
    task automatic model_step();
        bit ev_up[2], ev_dn[2];
        int ns[2];
        bit np[2];
        bit commit, won, free, nv, ct;
        int g;
        if (!rst_n) begin
            m_score = '{0, 0}; m_pend = '{0, 0}; m_pdir = '{0, 0}; m_prev = '{0, 0, 0, 0};
            m_valid = 0; m_team = 0; m_dir = 0; m_rr = 1; m_drop = 0; m_state = 0;
            return;
        end
        ev_up[0] = btn[0] && !m_prev[0];
        ev_dn[0] = btn[1] && !m_prev[1];
        ev_up[1] = btn[2] && !m_prev[2];
        ev_dn[1] = btn[3] && !m_prev[3];
        for (int i = 0; i < 4; i++) m_prev[i] = btn[i];
        ns = m_score;
        np = m_pend;
        ct = m_team;
        commit = m_valid && ready && !clr;
        if (commit) begin
            if (m_dir) ns[m_team] = ns[m_team] + 1;
            else if (ns[m_team] > 0) ns[m_team] = ns[m_team] - 1;
        end
        won = commit && m_dir && (ns[m_team] == WIN);
        nv = m_valid && !commit;
        free = !m_valid || commit;
        if (free) begin
            g = -1;
            if (m_pend[0] && m_pend[1]) begin
                g = m_rr ? 0 : 1;
                m_rr = g[0];
            end else if (m_pend[0]) g = 0;
            else if (m_pend[1]) g = 1;
            if (g >= 0) begin
                np[g] = 0;
                if (m_pdir[g] || ns[g] > 0) begin
                    nv = 1; m_team = g[0]; m_dir = m_pdir[g];
                end
            end
        end
        m_drop = 0;
        if (m_state == 1) begin
            for (int t = 0; t < 2; t++) begin
                if (ev_up[t] != ev_dn[t]) begin
                    if (m_pend[t]) m_drop = 1;
                    else begin np[t] = 1; m_pdir[t] = ev_up[t]; end
                end
            end
        end
        if (m_state == 0 && start) m_state = 1;
        else if (m_state == 1 && won) m_state = ct ? 3 : 2;
        if (won) begin np = '{0, 0}; nv = 0; end
        if (clr) begin
            m_state = 0; ns = '{0, 0}; np = '{0, 0}; nv = 0; m_drop = 0;
        end
        m_score = ns;
        m_pend = np;
        m_valid = nv;
    endtask

    task automatic tick();
        if (rst_n && upd_valid && ready && !clr) hs_q.push_back(upd_team);
        @(posedge clk);
        model_step();
        #1;
        check("valid", upd_valid, m_valid);
        if (m_valid || !rst_n) begin
            check("team", upd_team, m_team);
            check("dir", upd_dir, m_dir);
        end
        check("score_a", score_a, m_score[0]);
        check("score_b", score_b, m_score[1]);
        check("state", state, m_state);
        check("drop", drop, m_drop);
        if (drop) drop_cnt++;
        if (upd_valid) valid_cnt++;
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] m);
        btn = m; tick();
        btn = 4'b0; tick();
    endtask

    task automatic new_game();
        clr = 1; tick(); clr = 0;
        start = 1; tick(); start = 0;
    endtask

    initial begin
        @(negedge clk);
        tick(); tick();
        check("rst_state", state, 0);
        rst_n = 1;
        tick();

        // single A-up, two-cycle latency to the channel
        ready = 1;
        new_game();
        press(4'b0001);
        check("lat_valid", upd_valid, 1);
        check("lat_team", upd_team, 0);
        check("lat_dir", upd_dir, 1);
        tick();
        check("a_one", score_a, 1);

        // simultaneous A/B presses alternate priority
        new_game();
        hs_q.delete();
        press(4'b0101); tick(); tick(); tick();
        press(4'b0101); tick(); tick(); tick();
        check("rr_n", hs_q.size(), 4);
        if (hs_q.size() == 4) begin
            check("rr_0", hs_q[0], 0);
            check("rr_1", hs_q[1], 1);
            check("rr_2", hs_q[2], 1);
            check("rr_3", hs_q[3], 0);
        end
        check("rr_a", score_a, 2);
        check("rr_b", score_b, 2);

        // backpressure: held, stored, dropped
        new_game();
        ready = 0;
        drop_cnt = 0;
        press(4'b0001); tick();
        press(4'b0001); tick();
        press(4'b0001); tick();
        check("drop_cnt", drop_cnt, 1);
        ready = 1;
        repeat (4) tick();
        check("bp_a", score_a, 2);

        // down at zero and cancelling presses
        new_game();
        valid_cnt = 0; drop_cnt = 0;
        press(4'b0010); tick(); tick();
        press(4'b0011); tick(); tick();
        check("zero_valid", valid_cnt, 0);
        check("zero_drop", drop_cnt, 0);
        check("zero_a", score_a, 0);

        // win for B, freeze, then clear
        new_game();
        repeat (3) begin press(4'b0100); tick(); end
        tick();
        check("win_state", state, 3);
        check("win_b", score_b, 3);
        press(4'b0001); tick(); tick();
        check("frozen_a", score_a, 0);
        check("frozen_st", state, 3);
        clr = 1; tick(); clr = 0;
        check("clr_state", state, 0);
        check("clr_b", score_b, 0);

        // asynchronous reset in the middle of a handshake
        new_game();
        press(4'b0001); tick();
        ready = 0;
        press(4'b0001);
        check("pre_rst_v", upd_valid, 1);
        #2 rst_n = 0;
        #1;
        check("arst_valid", upd_valid, 0);
        check("arst_a", score_a, 0);
        check("arst_state", state, 0);
        check("arst_team", upd_team, 0);
        check("arst_dir", upd_dir, 0);
        @(negedge clk);
        tick();
        rst_n = 1;
        tick();

        // clear together with a handshake
        new_game();
        press(4'b0001);
        clr = 1; ready = 1; tick(); clr = 0;
        check("clr_hs_a", score_a, 0);
        check("clr_hs_st", state, 0);

        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++) btn[b] = ($urandom_range(0, 3) == 0);
            start = ($urandom_range(0, 7) == 0);
            clr   = ($urandom_range(0, 59) == 0);
            ready = $urandom_range(0, 1) == 1;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_ctrl.md
Name: score_ctrl

Overview:
- Game controller for the scoreboard. It turns four debounced button levels (team A/B up/down) into score updates for two scores in the range 0..WIN_SCORE.
- Round-robin arbitration shares a single update channel (valid/ready) between the two teams. That channel feeds the display/counter side.
- A game FSM covers IDLE, PLAY and the two win states.

Parameters:
- BW, 7, width of each score output (enough for 0..99)
- WIN_SCORE, 11, score that ends the game; legal range 1..99

Ports:
- clk_i  in  1  system clock, rising edge
- rst_i  in  1  asynchronous reset, active-low
- start_i  in  1  pulse; IDLE -> PLAY
- clr_i  in  1  synchronous clear to IDLE
- btn_a_up_i, btn_a_dn_i, btn_b_up_i, btn_b_dn_i  in  1 each  debounced, synchronous button levels
- upd_ready_i  in  1  downstream accepts the update
- upd_valid_o  out  1  update pending on the channel
- upd_team_o  out  1  0 = A, 1 = B
- upd_dir_o  out  1  1 = up, 0 = down
- score_a_o, score_b_o  out  BW each  committed scores
- state_o  out  2  00 IDLE, 01 PLAY, 10 WON_A, 11 WON_B
- drop_o  out  1  one-cycle pulse when an event is lost

Behaviour:
- Reset (rst_i low, asynchronous) forces:
  - scores = 0, state = IDLE, upd_valid_o = 0, upd_team_o = 0, upd_dir_o = 0, drop_o = 0
  - all pending flags cleared, button history regs = 0, RR pointer = B (so A wins the first tie)
  - Reset mid-handshake discards the pending update.
- Edge detect: an event is btn & ~btn_q, registered each cycle. Events are accepted only in PLAY; they are ignored in IDLE, WON_A and WON_B.
- Per-team pending slot, 1-deep, holds the direction:
  - Up and down events of the same team in the same cycle cancel; nothing is stored.
  - Event arrives while that team's slot is full -> event discarded, drop_o = 1 for one cycle.
- Grant:
  - When upd_valid_o = 0, or a handshake completes this cycle, the arbiter picks a non-empty slot.
  - Both slots full -> team != RR pointer wins; pointer := granted team.
  - Granted slot is cleared; upd_valid_o/team/dir register at the next edge.
- Boundary filter at grant: a down request on a score of 0 is discarded silently (no channel transaction, no drop_o).
- Latency: event sampled at edge k -> slot set at edge k -> upd_valid_o high after edge k+1 (best case).
- Handshake:
  - upd_valid_o and the team/dir fields are held stable until upd_valid_o & upd_ready_i at an edge.
  - At that edge the score is updated (+1 or -1), and the next grant may load back-to-back.
- Win:
  - If the committed up-update makes a score equal WIN_SCORE, the state goes to WON_A or WON_B at the same edge.
  - On entering a WON state: both slots cleared, upd_valid_o = 0 next cycle, scores frozen.
- start_i: IDLE -> PLAY only; ignored elsewhere.
- clr_i:
  - Highest priority, any state: scores = 0, state = IDLE, slots cleared, upd_valid_o = 0.
  - A handshake in the same cycle is not committed.
- Scores never exceed WIN_SCORE and never go below 0; no wrap-around.

Decomposition:
- Package score_pkg: state encoding (IDLE, PLAY, WON_A, WON_B), team constants (TEAM_A = 0, TEAM_B = 1), direction constants, default WIN_SCORE.
- Sub-module btn_edge: one register plus a rising-edge pulse, instantiated 4 times.
- Arbiter, slots, FSM and score registers remain in score_ctrl.

Test Plan:
- Reset, start_i, single A-up pulse, ready = 1 -> upd_valid_o high 2 cycles after the event with team = 0, dir = 1; score_a_o = 1 after the handshake edge.
- A-up and B-up in the same cycle, twice, ready = 1 -> grant order A, B, then B, A (round-robin); both scores = 2.
- ready held 0, three A-up pulses 3 cycles apart -> first held on the channel, second stored in the slot, third gives drop_o pulse; after ready = 1, score_a_o = 2.
- A-down at score 0 -> no upd_valid_o, no drop_o, score stays 0; A-up and A-down in the same cycle -> no change.
- WIN_SCORE = 3, three B-ups -> state_o = 11 at the third handshake; later presses ignored; clr_i -> scores 0, state IDLE.
- rst_i low mid-handshake (valid = 1, ready = 0) -> all outputs 0 immediately, asynchronously; clr_i asserted together with a handshake -> score not incremented.
